// File: rtl/wb_req_pkg.sv
// Shared types and widths for the Wishbone request master.
package wb_req_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // 69-bit queued command
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic              timeout;
  } rsp_t;

  // Saturating statistics increment
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Command FIFO: register storage, wrap-bit pointers, registered ready/empty flags.
module wb_req_fifo
  import wb_req_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i_,
  input  logic i_push,
  input  cmd_t i_data,
  input  logic i_pop,
  output cmd_t o_head,
  output logic o_ready,
  output logic o_empty,
  output logic o_empty_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned AW    = PTR_W + 1;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic          r_empty;
  logic          r_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_full_nxt;

  assign w_push       = i_push && r_ready;
  assign w_pop        = i_pop && !r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + AW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);

  // Full when indices match but wrap bits differ
  assign w_full_nxt    = (w_wr_ptr_nxt[PTR_W] != w_rd_ptr_nxt[PTR_W]) &&
                         (w_wr_ptr_nxt[PTR_W-1:0] == w_rd_ptr_nxt[PTR_W-1:0]);
  assign o_empty_nxt_c = (w_wr_ptr_nxt == w_rd_ptr_nxt);

  always_ff @(posedge clk_i or negedge rst_i_) begin
    if (!rst_i_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_ready  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_empty  <= o_empty_nxt_c;
      r_ready  <= !w_full_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_ready = r_ready;
  assign o_empty = r_empty;

endmodule

// File: rtl/wb_req_master.sv
// Wishbone classic single-beat master fed by a command FIFO, one response per command.
// Optional response statistics counters: define WB_REQ_STATS_EN.
module wb_req_master
  import wb_req_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk_i,
  input  logic              rst_i_,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
`ifdef WB_REQ_STATS_EN
  output logic [STAT_W-1:0] stat_ok_o,
  output logic [STAT_W-1:0] stat_err_o,
  output logic [STAT_W-1:0] stat_tmo_o,
`endif
  output logic              busy_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  cmd_t             r_wb_cmd;
  cmd_t             w_wb_cmd_nxt;
  logic             r_wb_cyc;
  logic             w_wb_cyc_nxt;
  rsp_t             r_rsp;
  rsp_t             w_rsp_nxt;
  logic             r_rsp_valid;
  logic             w_rsp_valid_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             r_busy;

  cmd_t             w_cmd_in;
  cmd_t             w_fifo_head;
  logic             w_fifo_ready;
  logic             w_fifo_empty;
  logic             w_fifo_empty_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, data: cmd_data_i, sel: cmd_sel_i};
  assign w_push   = cmd_valid_i && w_fifo_ready;

  wb_req_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i_        (rst_i_),
    .i_push        (w_push),
    .i_data        (w_cmd_in),
    .i_pop         (w_pop),
    .o_head        (w_fifo_head),
    .o_ready       (w_fifo_ready),
    .o_empty       (w_fifo_empty),
    .o_empty_nxt_c (w_fifo_empty_nxt)
  );

  // Next-state and next-register values
  always_comb begin
    w_state_nxt     = r_state;
    w_wb_cmd_nxt    = r_wb_cmd;
    w_wb_cyc_nxt    = r_wb_cyc;
    w_rsp_nxt       = r_rsp;
    w_rsp_valid_nxt = r_rsp_valid;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_pop           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_wb_cmd_nxt   = w_fifo_head;
          w_wb_cyc_nxt   = 1'b1;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_ack_i || wb_err_i) begin
          // err outranks ack; data only from a clean read ack
          w_wb_cyc_nxt      = 1'b0;
          w_wb_cmd_nxt.we   = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_nxt.err     = wb_err_i;
          w_rsp_nxt.timeout = 1'b0;
          w_rsp_nxt.data    = (wb_ack_i && !wb_err_i && !r_wb_cmd.we) ? wb_data_i : '0;
          w_state_nxt       = ST_RSP;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_wb_cyc_nxt      = 1'b0;
          w_wb_cmd_nxt.we   = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_nxt.err     = 1'b0;
          w_rsp_nxt.timeout = 1'b1;
          w_rsp_nxt.data    = '0;
          w_state_nxt       = ST_RSP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_nxt       = '0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i_) begin
    if (!rst_i_) begin
      r_state     <= ST_IDLE;
      r_wb_cmd    <= '0;
      r_wb_cyc    <= 1'b0;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
      r_wait_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wb_cmd    <= w_wb_cmd_nxt;
      r_wb_cyc    <= w_wb_cyc_nxt;
      r_rsp       <= w_rsp_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_busy      <= !w_fifo_empty_nxt || (w_state_nxt != ST_IDLE);
    end
  end

`ifdef WB_REQ_STATS_EN
  logic              w_rsp_fire;
  logic [STAT_W-1:0] r_stat_ok;
  logic [STAT_W-1:0] r_stat_err;
  logic [STAT_W-1:0] r_stat_tmo;

  assign w_rsp_fire = r_rsp_valid && rsp_ready_i;

  // Count each response kind at its handshake edge
  always_ff @(posedge clk_i or negedge rst_i_) begin
    if (!rst_i_) begin
      r_stat_ok  <= '0;
      r_stat_err <= '0;
      r_stat_tmo <= '0;
    end else if (w_rsp_fire) begin
      if (r_rsp.timeout) begin
        r_stat_tmo <= sat_inc(r_stat_tmo);
      end else if (r_rsp.err) begin
        r_stat_err <= sat_inc(r_stat_err);
      end else begin
        r_stat_ok <= sat_inc(r_stat_ok);
      end
    end
  end

  assign stat_ok_o  = r_stat_ok;
  assign stat_err_o = r_stat_err;
  assign stat_tmo_o = r_stat_tmo;
`endif

  assign cmd_ready_o   = w_fifo_ready;
  assign wb_addr_o     = r_wb_cmd.addr;
  assign wb_data_o     = r_wb_cmd.data;
  assign wb_sel_o      = r_wb_cmd.sel;
  assign wb_we_o       = r_wb_cmd.we;
  assign wb_cyc_o      = r_wb_cyc;
  assign wb_stb_o      = r_wb_cyc;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp.data;
  assign rsp_err_o     = r_rsp.err;
  assign rsp_timeout_o = r_rsp.timeout;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_wb_req_master.sv
// Directed bench for wb_req_master (CMD_DEPTH=4, TIMEOUT_CYC=8).
module tb_wb_req_master;

  logic        clk_i = 1'b0;
  logic        rst_i_;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_data_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_data_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic        busy_o;
`ifdef WB_REQ_STATS_EN
  logic [15:0] stat_ok_o, stat_err_o, stat_tmo_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wb_req_master #(.CMD_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i_(rst_i_),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
`ifdef WB_REQ_STATS_EN
    .stat_ok_o(stat_ok_o), .stat_err_o(stat_err_o), .stat_tmo_o(stat_tmo_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Offer one command from a falling edge; return at the falling edge after it is pushed
  task automatic push_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output bit ok);
    ok = 1'b0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_data_i = d; cmd_sel_i = s;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready_o) begin
        ok = 1'b1;
        @(negedge clk_i);
        break;
      end
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_cyc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wb_cyc_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cmd_ready_o); end
    n_cmp++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin n_err++; $display("FAIL rst_ctl: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o}); end
    n_cmp++; if ({wb_addr_o, wb_data_o, rsp_data_o} !== 96'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", {wb_addr_o, wb_data_o, rsp_data_o}); end
    rst_i_ = 1'b1;
  endtask

  task automatic test_single_write();
    bit ok;
    push_cmd(1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'hF, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_push: got not accepted want accepted"); end
    n_cmp++; if ({wb_cyc_o, busy_o} !== 2'b01) begin n_err++; $display("FAIL wr_lat0: got cyc,busy=%b want 01", {wb_cyc_o, busy_o}); end
    @(negedge clk_i);
    n_cmp++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin n_err++; $display("FAIL wr_ctl: got %b want 111", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    n_cmp++; if ({wb_addr_o, wb_data_o, wb_sel_o} !== {32'h0000_0100, 32'hA5A5_5A5A, 4'hF}) begin n_err++; $display("FAIL wr_bus: got %h want 00000100a5a55a5af", {wb_addr_o, wb_data_o, wb_sel_o}); end
    repeat (2) @(negedge clk_i);
    n_cmp++; if ({wb_cyc_o, wb_stb_o, wb_addr_o} !== {2'b11, 32'h0000_0100}) begin n_err++; $display("FAIL wr_hold: got %h want 300000100", {wb_cyc_o, wb_stb_o, wb_addr_o}); end
    wb_ack_i = 1'b1; wb_data_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    wb_ack_i = 1'b0; wb_data_i = 32'h0;
    n_cmp++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin n_err++; $display("FAIL wr_drop: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b100) begin n_err++; $display("FAIL wr_rsp: got %b want 100", {rsp_valid_o, rsp_err_o, rsp_timeout_o}); end
    n_cmp++; if (rsp_data_o !== 32'h0) begin n_err++; $display("FAIL wr_rdata: got %h want 0", rsp_data_o); end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    n_cmp++; if ({rsp_valid_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL wr_done: got %b want 00", {rsp_valid_o, busy_o}); end
  endtask

  task automatic test_read();
    bit ok;
    push_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, ok);
    wait_cyc(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_start: got no cyc want cyc"); end
    n_cmp++; if ({wb_we_o, wb_addr_o} !== {1'b0, 32'h0000_0100}) begin n_err++; $display("FAIL rd_bus: got %h want 000000100", {wb_we_o, wb_addr_o}); end
    wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    wb_ack_i = 1'b0; wb_data_i = 32'h0;
    n_cmp++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin n_err++; $display("FAIL rd_drop: got %b want 00", {wb_cyc_o, wb_stb_o}); end
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b100) begin n_err++; $display("FAIL rd_rsp: got %b want 100", {rsp_valid_o, rsp_err_o, rsp_timeout_o}); end
    n_cmp++; if (rsp_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rsp_data_o); end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_done: got %b want 0", rsp_valid_o); end
  endtask

  // Five reads with responses stalled, immediate-ack slave returning addr ^ C0DE0000
  task automatic test_back_to_back();
    logic [31:0] exp_data [5];
    int accepted = 0;
    int terms = 0;
    int got = 0;
    for (int i = 0; i < 5; i++) exp_data[i] = (32'h0000_1000 + 32'(i) * 32'd4) ^ 32'hC0DE_0000;
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 30 && accepted < 5; c++) begin
      wb_ack_i = wb_cyc_o; wb_data_i = wb_addr_o ^ 32'hC0DE_0000;
      if (wb_cyc_o) terms++;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_data_i = 32'h0; cmd_sel_i = 4'hF;
      cmd_addr_i = 32'h0000_1000 + 32'(accepted) * 32'd4;
      if (cmd_ready_o) accepted++;
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    n_cmp++; if (accepted != 5) begin n_err++; $display("FAIL b2b_accept: got %0d want 5", accepted); end
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full: got ready=%b want 0", cmd_ready_o); end
    for (int c = 0; c < 4; c++) begin
      wb_ack_i = wb_cyc_o; wb_data_i = wb_addr_o ^ 32'hC0DE_0000;
      if (wb_cyc_o) terms++;
      @(negedge clk_i);
    end
    n_cmp++; if (terms != 1) begin n_err++; $display("FAIL b2b_one_cycle: got %0d bus cycles want 1", terms); end
    n_cmp++; if ({rsp_valid_o, rsp_data_o} !== {1'b1, exp_data[0]}) begin n_err++; $display("FAIL b2b_held: got %h want 1%h", {rsp_valid_o, rsp_data_o}, exp_data[0]); end
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_still_full: got %b want 0", cmd_ready_o); end
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 60 && got < 5; c++) begin
      wb_ack_i = wb_cyc_o; wb_data_i = wb_addr_o ^ 32'hC0DE_0000;
      if (rsp_valid_o) begin
        n_cmp++; if (rsp_data_o !== exp_data[got]) begin n_err++; $display("FAIL b2b_order%0d: got %h want %h", got, rsp_data_o, exp_data[got]); end
        got++;
      end
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0; wb_ack_i = 1'b0; wb_data_i = 32'h0;
    n_cmp++; if (got != 5) begin n_err++; $display("FAIL b2b_drain: got %0d responses want 5", got); end
    n_cmp++; if ({busy_o, cmd_ready_o, wb_cyc_o} !== 3'b010) begin n_err++; $display("FAIL b2b_idle: got %b want 010", {busy_o, cmd_ready_o, wb_cyc_o}); end
  endtask

  task automatic test_err_priority();
    bit ok;
    push_cmd(1'b0, 32'h0000_0200, 32'h0, 4'h3, ok);
    wait_cyc(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL err_start: got no cyc want cyc"); end
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_data_i = 32'h1234_5678;
    @(negedge clk_i);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = 32'h0;
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b110) begin n_err++; $display("FAIL err_flags: got %b want 110", {rsp_valid_o, rsp_err_o, rsp_timeout_o}); end
    n_cmp++; if (rsp_data_o !== 32'h0) begin n_err++; $display("FAIL err_data: got %h want 0", rsp_data_o); end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    bit held = 1'b1;
    push_cmd(1'b0, 32'h0000_0300, 32'h0, 4'hF, ok);
    wait_cyc(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_start: got no cyc want cyc"); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_i);
      if (wb_cyc_o !== 1'b1) held = 1'b0;
    end
    n_cmp++; if (!held) begin n_err++; $display("FAIL tmo_hold: got early drop want 8 cycles of cyc"); end
    @(negedge clk_i);
    n_cmp++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin n_err++; $display("FAIL tmo_drop: got %b want 00", {wb_cyc_o, wb_stb_o}); end
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_data_o} !== {3'b101, 32'h0}) begin n_err++; $display("FAIL tmo_rsp: got %h want 500000000", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_data_o}); end
    wb_ack_i = 1'b1; wb_data_i = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk_i);
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_data_o} !== {3'b101, 32'h0}) begin n_err++; $display("FAIL tmo_late_ack: got %h want 500000000", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_data_o}); end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    wb_ack_i = 1'b0; wb_data_i = 32'h0;
    n_cmp++; if ({rsp_valid_o, busy_o, wb_cyc_o} !== 3'b000) begin n_err++; $display("FAIL tmo_after: got %b want 000", {rsp_valid_o, busy_o, wb_cyc_o}); end
    push_cmd(1'b1, 32'h0000_0304, 32'h0F0F_0F0F, 4'h1, ok);
    wait_cyc(ok);
    n_cmp++; if (!ok || {wb_we_o, wb_addr_o, wb_data_o, wb_sel_o} !== {1'b1, 32'h0000_0304, 32'h0F0F_0F0F, 4'h1}) begin n_err++; $display("FAIL tmo_next_bus: got %h want 1000003040f0f0f0f1", {wb_we_o, wb_addr_o, wb_data_o, wb_sel_o}); end
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_data_o} !== {3'b100, 32'h0}) begin n_err++; $display("FAIL tmo_next_rsp: got %h want 400000000", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_data_o}); end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

`ifdef WB_REQ_STATS_EN
  task automatic test_stats();
    n_cmp++; if ({stat_ok_o, stat_err_o, stat_tmo_o} !== {16'd8, 16'd1, 16'd1}) begin n_err++; $display("FAIL stats: got %h want 000800010001", {stat_ok_o, stat_err_o, stat_tmo_o}); end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    bit quiet = 1'b1;
    rsp_ready_i = 1'b0;
    push_cmd(1'b0, 32'h0000_0400, 32'h0, 4'hF, ok);
    push_cmd(1'b0, 32'h0000_0404, 32'h0, 4'hF, ok);
    push_cmd(1'b0, 32'h0000_0408, 32'h0, 4'hF, ok);
    n_cmp++; if ({wb_cyc_o, busy_o} !== 2'b11) begin n_err++; $display("FAIL rstm_pre: got %b want 11", {wb_cyc_o, busy_o}); end
    #2 rst_i_ = 1'b0;
    #1;
    n_cmp++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o} !== 4'b0000) begin n_err++; $display("FAIL rstm_async: got %b want 0000", {wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o}); end
    @(negedge clk_i);
    rst_i_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (wb_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (!quiet) begin n_err++; $display("FAIL rstm_quiet: got activity after reset want none"); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rstm_ready: got %b want 1", cmd_ready_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i_ = 1'b0;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 32'h0; cmd_data_i = 32'h0; cmd_sel_i = 4'h0;
    rsp_ready_i = 1'b0; wb_data_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    test_reset();
    test_single_write();
    test_read();
    test_back_to_back();
    test_err_priority();
    test_timeout();
`ifdef WB_REQ_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
